// File: rtl/interrupt_sequencer.sv
// Interrupt/RTI micro-op sequencer: injects stack push/pop and vector-load ops into decode.
// Interrupt entry 2 cycles after the request edge; i_stall freezes the FSM while edges keep being captured.
module interrupt_sequencer (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_interrupt,
  input  logic       i_rti,
  input  logic       i_stall,
  input  logic       i_branch_pending,
  output logic       o_push_pc,
  output logic       o_push_flags,
  output logic       o_pop_pc,
  output logic       o_pop_flags,
  output logic       o_load_vector,
  output logic       o_inject,
  output logic       o_freeze_fetch,
  output logic       o_in_isr,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    IDLE           = 3'b000,
    INT_PUSH_PC    = 3'b001,
    INT_PUSH_FLAGS = 3'b010,
    INT_VECTOR     = 3'b011,
    RTI_POP_FLAGS  = 3'b100,
    RTI_POP_PC     = 3'b101,
    RTI_FLUSH      = 3'b110
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   int_q;
  logic   int_edge;
  logic   pending;
  logic   pending_nxt;
  logic   in_isr;
  logic   in_isr_nxt;

  assign int_edge = i_interrupt & ~int_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      int_q   <= 1'b0;
      pending <= 1'b0;
      in_isr  <= 1'b0;
    end else begin
      state   <= state_nxt;
      int_q   <= i_interrupt;
      pending <= pending_nxt;
      in_isr  <= in_isr_nxt;
    end
  end

  // A new edge is always captured, even on stall or on the cycle pending is consumed.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending | int_edge;
    in_isr_nxt  = in_isr;
    case (state)
      IDLE: begin
        if (!i_stall) begin
          if (i_rti) begin
            state_nxt = RTI_POP_FLAGS;
          end else if (pending && !in_isr && !i_branch_pending) begin
            state_nxt   = INT_PUSH_PC;
            pending_nxt = int_edge;
          end
        end
      end
      INT_PUSH_PC:    if (!i_stall) state_nxt = INT_PUSH_FLAGS;
      INT_PUSH_FLAGS: if (!i_stall) state_nxt = INT_VECTOR;
      INT_VECTOR: begin
        if (!i_stall) begin
          state_nxt  = IDLE;
          in_isr_nxt = 1'b1;
        end
      end
      RTI_POP_FLAGS:  if (!i_stall) state_nxt = RTI_POP_PC;
      RTI_POP_PC:     if (!i_stall) state_nxt = RTI_FLUSH;
      RTI_FLUSH: begin
        if (!i_stall) begin
          state_nxt  = IDLE;
          in_isr_nxt = 1'b0;
        end
      end
      default:        state_nxt = IDLE;
    endcase
  end

  assign o_push_pc      = (state == INT_PUSH_PC);
  assign o_push_flags   = (state == INT_PUSH_FLAGS);
  assign o_load_vector  = (state == INT_VECTOR);
  assign o_pop_flags    = (state == RTI_POP_FLAGS);
  assign o_pop_pc       = (state == RTI_POP_PC);
  assign o_inject       = (state != IDLE);
  assign o_freeze_fetch = (state != IDLE);
  assign o_in_isr       = in_isr;
  assign o_state        = state;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios plus random traffic against a micro-op queue model.
module tb_interrupt_sequencer;

  localparam int S_IDLE       = 0;
  localparam int S_PUSH_PC    = 1;
  localparam int S_PUSH_FLAGS = 2;
  localparam int S_VECTOR     = 3;
  localparam int S_POP_FLAGS  = 4;
  localparam int S_POP_PC     = 5;
  localparam int S_FLUSH      = 6;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_interrupt;
  logic       i_rti;
  logic       i_stall;
  logic       i_branch_pending;
  logic       o_push_pc;
  logic       o_push_flags;
  logic       o_pop_pc;
  logic       o_pop_flags;
  logic       o_load_vector;
  logic       o_inject;
  logic       o_freeze_fetch;
  logic       o_in_isr;
  logic [2:0] o_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: queue of micro-ops still to execute (front = current), empty = idle.
  int ops[$];
  bit m_pend;
  bit m_isr;
  bit m_prev;

  interrupt_sequencer dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_interrupt      (i_interrupt),
    .i_rti            (i_rti),
    .i_stall          (i_stall),
    .i_branch_pending (i_branch_pending),
    .o_push_pc        (o_push_pc),
    .o_push_flags     (o_push_flags),
    .o_pop_pc         (o_pop_pc),
    .o_pop_flags      (o_pop_flags),
    .o_load_vector    (o_load_vector),
    .o_inject         (o_inject),
    .o_freeze_fetch   (o_freeze_fetch),
    .o_in_isr         (o_in_isr),
    .o_state          (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    ops.delete();
    m_pend = 1'b0;
    m_isr  = 1'b0;
    m_prev = 1'b0;
  endtask

  task automatic model_edge();
    bit rise;
    int done;
    rise   = i_interrupt && !m_prev;
    m_prev = i_interrupt;
    if (!i_stall) begin
      if (ops.size() != 0) begin
        done = ops.pop_front();
        if (done == S_VECTOR) m_isr = 1'b1;
        if (done == S_FLUSH)  m_isr = 1'b0;
      end else if (i_rti) begin
        ops.push_back(S_POP_FLAGS);
        ops.push_back(S_POP_PC);
        ops.push_back(S_FLUSH);
      end else if (m_pend && !m_isr && !i_branch_pending) begin
        ops.push_back(S_PUSH_PC);
        ops.push_back(S_PUSH_FLAGS);
        ops.push_back(S_VECTOR);
        m_pend = 1'b0;
      end
    end
    if (rise) m_pend = 1'b1;
  endtask

  task automatic compare_all();
    int   cur;
    logic one_hot;
    cur     = (ops.size() != 0) ? ops[0] : S_IDLE;
    one_hot = ($countones({o_push_pc, o_push_flags, o_pop_pc, o_pop_flags, o_load_vector}) <= 1);
    check_eq("state",       32'(o_state),        32'(cur));
    check_eq("push_pc",     32'(o_push_pc),      32'(cur == S_PUSH_PC));
    check_eq("push_flags",  32'(o_push_flags),   32'(cur == S_PUSH_FLAGS));
    check_eq("load_vector", 32'(o_load_vector),  32'(cur == S_VECTOR));
    check_eq("pop_flags",   32'(o_pop_flags),    32'(cur == S_POP_FLAGS));
    check_eq("pop_pc",      32'(o_pop_pc),       32'(cur == S_POP_PC));
    check_eq("inject",      32'(o_inject),       32'(cur != S_IDLE));
    check_eq("freeze",      32'(o_freeze_fetch), 32'(cur != S_IDLE));
    check_eq("in_isr",      32'(o_in_isr),       32'(m_isr));
    check_eq("one_hot",     32'(one_hot),        32'd1);
  endtask

  // Drive one cycle of inputs, clock it, then compare at the falling edge.
  task automatic step(input logic intr, input logic rti, input logic stall, input logic br);
    i_interrupt      = intr;
    i_rti            = rti;
    i_stall          = stall;
    i_branch_pending = br;
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    cyc++;
    compare_all();
  endtask

  initial begin
    i_reset_n        = 1'b0;
    i_interrupt      = 1'b0;
    i_rti            = 1'b0;
    i_stall          = 1'b0;
    i_branch_pending = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    compare_all();
    check_eq("rst_state", 32'(o_state), 32'd0);
    i_reset_n = 1'b1;
    cyc = 0;

    // Basic entry: request first high in cycle 10
    repeat (10) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check_eq("b_c11_idle", 32'(o_state), 32'd0);
    step(1, 0, 0, 0);
    check_eq("b_c12_push_pc", 32'(o_push_pc), 32'd1);
    step(0, 0, 0, 0);
    check_eq("b_c13_push_flags", 32'(o_push_flags), 32'd1);
    step(0, 0, 0, 0);
    check_eq("b_c14_vector", 32'(o_load_vector), 32'd1);
    step(0, 0, 0, 0);
    check_eq("b_c15_state", 32'(o_state), 32'd0);
    check_eq("b_c15_isr", 32'(o_in_isr), 32'd1);

    // Return from the ISR
    step(0, 1, 0, 0);
    check_eq("rti_pop_flags", 32'(o_state), 32'd4);
    step(0, 0, 0, 0);
    check_eq("rti_pop_pc", 32'(o_state), 32'd5);
    step(0, 0, 0, 0);
    check_eq("rti_flush", 32'(o_state), 32'd6);
    step(0, 0, 0, 0);
    check_eq("rti_idle_isr", 32'(o_in_isr), 32'd0);

    // Deferral by an unresolved branch
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    repeat (4) begin
      step(1, 0, 0, 1);
      check_eq("d_held_idle", 32'(o_state), 32'd0);
    end
    step(0, 0, 0, 0);
    check_eq("d_push_pc", 32'(o_push_pc), 32'd1);

    // Stall while pushing flags
    step(0, 0, 0, 0);
    check_eq("s_push_flags", 32'(o_push_flags), 32'd1);
    repeat (3) begin
      step(0, 0, 1, 0);
      check_eq("s_flags_held", 32'(o_push_flags), 32'd1);
      check_eq("s_isr_held", 32'(o_in_isr), 32'd0);
    end
    step(0, 0, 0, 0);
    check_eq("s_vector", 32'(o_load_vector), 32'd1);
    step(0, 0, 0, 0);
    check_eq("s_isr_set", 32'(o_in_isr), 32'd1);

    // Nested request waits for the RTI
    step(1, 0, 0, 0);
    repeat (2) begin
      step(1, 0, 0, 0);
      check_eq("n_blocked", 32'(o_state), 32'd0);
    end
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("n_isr_clr", 32'(o_in_isr), 32'd0);
    step(0, 0, 0, 0);
    check_eq("n_push_pc", 32'(o_push_pc), 32'd1);
    repeat (3) step(0, 0, 0, 0);
    check_eq("n_isr_set", 32'(o_in_isr), 32'd1);

    // RTI beats a pending interrupt
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check_eq("p_rti_first", 32'(o_state), 32'd4);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("p_int_after", 32'(o_push_pc), 32'd1);
    repeat (3) step(0, 0, 0, 0);

    // Asynchronous reset inside RTI_POP_PC, with the request held high through reset
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_eq("r_in_pop_pc", 32'(o_state), 32'd5);
    #2;
    i_reset_n   = 1'b0;
    i_interrupt = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_eq("r_async_pop_pc", 32'(o_pop_pc), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    check_eq("r_after_release", 32'(o_state), 32'd0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_eq("r_held_intr", 32'(o_push_pc), 32'd1);
    repeat (3) step(0, 0, 0, 0);

    // Random traffic with occasional asynchronous resets
    for (int k = 0; k < 3000; k++) begin
      logic intr;
      intr = ($urandom_range(0, 3) == 0) ? ~i_interrupt : i_interrupt;
      step(intr, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      if ((k % 500) == 499) begin
        #2;
        i_reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge i_clk);
        i_reset_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
